// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable bit period, word length, parity and stop bits.
// The line is synchronized, each bit is decided by a 3-sample majority vote
// around mid-bit, and every frame ends in a one-cycle rx_data_vld pulse that
// carries the error qualifiers (parity_err, frame_err, break_det).
module uart_rx_cfg #(
  parameter int CLK_DIV   = 434,  // clk cycles per bit, 16..8191
  parameter int DATA_BITS = 8,    // data bits per frame, 5..9
  parameter int PARITY    = 0,    // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1     // 1 or 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] MID_M1 = CW'(CLK_DIV / 2 - 2);
  localparam logic [CW-1:0] MID    = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] MID_P1 = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] LAST   = CW'(CLK_DIV - 1);
  localparam logic          ODD    = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, WAIT_HI
  } state_t;

  state_t state_q, state_d;

  logic                 s1, s2, s3;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_idx_q;
  logic                 v_a_q, v_b_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_acc_q;
  logic                 frame_acc_q;
  logic                 all_zero_q;

  logic fall, at_wrap, at_dec, bit_val, last_stop, frame_err_now;

  assign fall          = !s2 && s3;
  assign at_wrap       = (cnt_q == LAST);
  assign at_dec        = (cnt_q == MID_P1);
  // Majority of the samples taken at MID-1, MID and the current one at MID+1.
  assign bit_val       = (v_a_q & v_b_q) | (v_a_q & s2) | (v_b_q & s2);
  assign last_stop     = (bit_idx_q == 4'(STOP_BITS - 1));
  assign frame_err_now = frame_acc_q | ~bit_val;
  assign busy          = (state_q != IDLE);

  // Three-flop synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour (a real shift chain).
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rs232_rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d; no latch inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START: begin
        if (at_dec && bit_val) state_d = IDLE;   // false start
        else if (at_wrap)      state_d = DATA;
      end
      DATA:    if (at_wrap && bit_idx_q == 4'(DATA_BITS))
                 state_d = (PARITY != 0) ? PAR : STOP;
      PAR:     if (at_wrap) state_d = STOP;
      STOP:    if (at_dec && last_stop)
                 state_d = frame_err_now ? WAIT_HI : IDLE;
      WAIT_HI: if (s2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit-period counter: held at 0 while idle, free-running 0..CLK_DIV-1 in a frame.
  always_ff @(posedge clk) begin
    if (!rst_n)                                   cnt_q <= '0;
    else if (state_q == IDLE || state_q == WAIT_HI) cnt_q <= '0;
    else if (at_wrap)                             cnt_q <= '0;
    else                                          cnt_q <= cnt_q + 1'b1;
  end

  // Bit sampling, shift register, error accumulation and frame result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_a_q       <= 1'b0;
      v_b_q       <= 1'b0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      frame_acc_q <= 1'b0;
      all_zero_q  <= 1'b0;
      rx_data     <= '0;
      rx_data_vld <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      // Result flags are only meaningful alongside the valid pulse.
      rx_data_vld <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;

      if (cnt_q == MID_M1) v_a_q <= s2;
      if (cnt_q == MID)    v_b_q <= s2;

      if (state_q == IDLE && fall) begin
        bit_idx_q   <= '0;
        par_acc_q   <= 1'b0;
        frame_acc_q <= 1'b0;
        all_zero_q  <= 1'b1;
      end else if (at_dec) begin
        case (state_q)
          DATA: begin
            shift_q    <= {bit_val, shift_q[DATA_BITS-1:1]};
            par_acc_q  <= par_acc_q ^ bit_val;
            all_zero_q <= all_zero_q & ~bit_val;
            bit_idx_q  <= bit_idx_q + 4'd1;
          end
          PAR: begin
            par_acc_q  <= par_acc_q ^ bit_val;
            all_zero_q <= all_zero_q & ~bit_val;
          end
          STOP: begin
            frame_acc_q <= frame_err_now;
            all_zero_q  <= all_zero_q & ~bit_val;
            bit_idx_q   <= bit_idx_q + 4'd1;
            if (last_stop) begin
              rx_data     <= shift_q;
              rx_data_vld <= 1'b1;
              parity_err  <= (PARITY != 0) ? (par_acc_q ^ ODD) : 1'b0;
              frame_err   <= frame_err_now;
              break_det   <= all_zero_q & ~bit_val;
            end
          end
          default: ;
        endcase
      end else if (at_wrap && state_q != state_d) begin
        // Each new field counts its own bits from zero.
        bit_idx_q <= '0;
      end
    end
  end

endmodule
